// File: rtl/line_deserializer.sv
// Collects WORDS words (critical-word-first, wrapping) into one cache line and offers it on a valid/ready port.
// Line is valid the cycle after the last word; abort wins over every other request.
module line_deserializer #(
  parameter  int WORD_W = 32,
  parameter  int WORDS  = 8,
  localparam int IDX_W  = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  input  logic [IDX_W-1:0]          start_idx,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      word_strobe,
  output logic [IDX_W-1:0]          word_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   out_data,
  output logic                      busy,
  input  logic                      abort
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(WORDS - 1);

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_d;
  logic [IDX_W:0]            cnt_q;
  logic [WORD_W*WORDS-1:0]   line_q;
  logic                      out_valid_q;

  // WORDS is a power of two, so the natural IDX_W-bit overflow is the wrap.
  assign idx_d       = idx_q + IDX_W'(1);

  assign in_ready    = (state_q == S_FILL) && !abort;
  assign word_strobe = in_valid && in_ready;
  assign word_idx    = idx_q;
  assign out_valid   = out_valid_q;
  assign out_data    = line_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            idx_q   <= start_idx;
            cnt_q   <= '0;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            line_q[idx_q*WORD_W +: WORD_W] <= in_data;
            idx_q <= idx_d;
            cnt_q <= cnt_q + (IDX_W+1)'(1);
            if (cnt_q == CNT_LAST) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // A start alongside the handshake skips the IDLE bubble.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start_valid) begin
              idx_q   <= start_idx;
              cnt_q   <= '0;
              state_q <= S_FILL;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_deserializer.sv
// Bench for line_deserializer: table vectors, directed corner sequences, random traffic against a line model.
module tb_line_deserializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic [2:0]   start_idx;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         word_strobe;
  logic [2:0]   word_idx;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;
  logic         abort;

  line_deserializer #(.WORD_W(32), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_idx(start_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .word_strobe(word_strobe), .word_idx(word_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line model: a fill is "active" from start until handshake; m_n words received so far.
  bit          m_active;
  int          m_start;
  int          m_n;
  logic [31:0] m_line [8];

  function automatic logic [255:0] m_packed();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = m_line[k];
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_start = 0; m_n = 0;
    for (int k = 0; k < 8; k++) m_line[k] = '0;
  endtask

  task automatic model_update();
    if (abort) begin
      m_active = 0; m_n = 0;
    end else if (!m_active) begin
      if (start_valid) begin m_active = 1; m_start = int'(start_idx); m_n = 0; end
    end else if (m_n < 8) begin
      if (in_valid) begin m_line[(m_start + m_n) % 8] = in_data; m_n++; end
    end else if (out_ready) begin
      if (start_valid) begin m_start = int'(start_idx); m_n = 0; end
      else m_active = 0;
    end
  endtask

  task automatic apply(input bit sv, input logic [2:0] si, input bit iv, input logic [31:0] d,
                       input bit ordy, input bit ab);
    @(negedge clk);
    start_valid = sv; start_idx = si; in_valid = iv; in_data = d; out_ready = ordy; abort = ab;
    #1;
  endtask

  task automatic check_model();
    bit exp_rdy;
    bit exp_ov;
    exp_rdy = m_active && (m_n < 8) && !abort;
    exp_ov  = m_active && (m_n == 8);
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("word_strobe", 256'(word_strobe), 256'(in_valid && exp_rdy));
    if (in_valid && exp_rdy) chk("word_idx", 256'(word_idx), 256'((m_start + m_n) % 8));
    chk("out_valid", 256'(out_valid), 256'(exp_ov));
    chk("busy", 256'(busy), 256'(m_active));
    if (exp_ov) chk("out_data", out_data, m_packed());
  endtask

  task automatic step(input bit sv, input logic [2:0] si, input bit iv, input logic [31:0] d,
                      input bit ordy, input bit ab);
    apply(sv, si, iv, d, ordy, ab);
    check_model();
    model_update();
  endtask

  typedef struct {
    bit sv; logic [2:0] si; bit iv; logic [31:0] d; bit ordy;
    bit rdy; bit stb; logic [2:0] idx; bit ov; bit bsy;
    bit chk; logic [2:0] slot; logic [31:0] sdat;
  } vec_t;

  function automatic vec_t mk(bit sv, logic [2:0] si, bit iv, logic [31:0] d, bit ordy,
                              bit rdy, bit stb, logic [2:0] idx, bit ov, bit bsy,
                              bit c, logic [2:0] slot, logic [31:0] sdat);
    vec_t v;
    v.sv = sv; v.si = si; v.iv = iv; v.d = d; v.ordy = ordy;
    v.rdy = rdy; v.stb = stb; v.idx = idx; v.ov = ov; v.bsy = bsy;
    v.chk = c; v.slot = slot; v.sdat = sdat;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   acc;
    int   cyc;

    // Fill from slot 0, hand off, idle.
    tbl.push_back(mk(1, 3'd0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 1, 32'h1000_0000 + k, 0,  1, 1, 3'(k), 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  1, 3'd0, 32'h1000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 1,  1, 3'd7, 32'h1000_0007));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
    // Critical word in slot 5, wrapping.
    tbl.push_back(mk(1, 3'd5, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 1, 32'hA000_00A0 + k, 0,  1, 1, 3'((5 + k) % 8), 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  1, 3'd5, 32'hA000_00A0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 1,  1, 3'd4, 32'hA000_00A7));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));

    rst_n = 1'b0;
    start_valid = 0; start_idx = 0; in_valid = 0; in_data = 0; out_ready = 0; abort = 0;
    model_reset();
    #1;
    chk("rst out_valid", 256'(out_valid), 256'(0));
    chk("rst in_ready", 256'(in_ready), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst word_strobe", 256'(word_strobe), 256'(0));
    chk("rst out_data", out_data, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].sv, tbl[i].si, tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl[%0d] in_ready", i), 256'(in_ready), 256'(tbl[i].rdy));
      chk($sformatf("tbl[%0d] word_strobe", i), 256'(word_strobe), 256'(tbl[i].stb));
      if (tbl[i].stb) chk($sformatf("tbl[%0d] word_idx", i), 256'(word_idx), 256'(tbl[i].idx));
      chk($sformatf("tbl[%0d] out_valid", i), 256'(out_valid), 256'(tbl[i].ov));
      chk($sformatf("tbl[%0d] busy", i), 256'(busy), 256'(tbl[i].bsy));
      if (tbl[i].chk)
        chk($sformatf("tbl[%0d] slot%0d", i, tbl[i].slot), 256'(out_data[tbl[i].slot*32 +: 32]),
            256'(tbl[i].sdat));
      model_update();
    end

    // Gappy input: 1,0,0 pattern, then a long HOLD with in_valid pushing junk.
    step(1, 3'd3, 0, 0, 0, 0);
    acc = 0; cyc = 0;
    for (int i = 0; i < 40 && acc < 8; i++) begin
      step(0, 0, (i % 3) == 0, $urandom, 0, 0);
      if ((i % 3) == 0) acc++;
      cyc++;
    end
    chk("gappy fill cycles", 256'(cyc), 256'(22));
    for (int i = 0; i < 10; i++) step(1, 3'($urandom), 1, $urandom, 0, 0);

    // Back-to-back: handshake + start(2) together, first new word lands in slot 2.
    step(1, 3'd2, 0, 0, 1, 0);
    apply(0, 0, 1, 32'hB2B2_0002, 0, 0);
    chk("b2b out_valid", 256'(out_valid), 256'(0));
    chk("b2b busy", 256'(busy), 256'(1));
    chk("b2b word_idx", 256'(word_idx), 256'(2));
    chk("b2b word_strobe", 256'(word_strobe), 256'(1));
    model_update();
    for (int k = 1; k < 8; k++) step(0, 0, 1, $urandom, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // Abort after 3 words with a word offered that same cycle.
    step(1, 3'd6, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, $urandom, 0, 0);
    apply(1, 3'd1, 1, 32'hDEAD_BEEF, 0, 1);
    chk("abort word_strobe", 256'(word_strobe), 256'(0));
    chk("abort in_ready", 256'(in_ready), 256'(0));
    model_update();
    step(0, 0, 1, 32'h1234_5678, 0, 0);
    chk("abort idle busy", 256'(busy), 256'(0));
    step(1, 3'd0, 0, 0, 0, 0);
    cyc = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      step(0, 0, 1, $urandom, 0, 0);
      cyc++;
    end
    chk("post-abort fill cycles", 256'(cyc), 256'(9));
    step(0, 0, 0, 0, 1, 0);

    // Asynchronous reset between edges during a fill.
    step(1, 3'd4, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, $urandom, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 256'(out_valid), 256'(0));
    chk("arst in_ready", 256'(in_ready), 256'(0));
    chk("arst busy", 256'(busy), 256'(0));
    chk("arst out_data", out_data, 256'(0));
    model_reset();
    start_valid = 0; in_valid = 0; out_ready = 0; abort = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 1, 32'h5555_AAAA, 0, 0);
    step(0, 0, 1, 32'h5555_AAAB, 0, 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 3, 3'($urandom), $urandom_range(0, 9) < 6, $urandom,
           $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_deserializer.md
Name: line_deserializer

Overview:
- Parametrised word-to-line deserializer for the cache refill path. It collects WORDS beats of WORD_W bits from the memory-side word bus into one cache line and presents that line to the cache with a valid/ready handshake.
- New over the fixed 8x32 shift version:
  - configurable width and depth;
  - critical-word-first start index with wrap-around;
  - valid/ready back-pressure on both sides;
  - per-word early-restart strobe;
  - synchronous abort.

Parameters:
- WORD_W, 32, bits per incoming word.
- WORDS, 8, words per line; power of two, at least 2.
- IDX_W, $clog2(WORDS), word index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to begin a line fill.
- start_idx  in  IDX_W  line slot of the first word to arrive (critical word).
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WORD_W  incoming word.
- word_strobe  out  1  a word was written this cycle (in_valid && in_ready).
- word_idx  out  IDX_W  slot written this cycle; meaningful only when word_strobe=1.
- out_valid  out  1  out_data holds a complete line.
- out_ready  in  1  consumer takes the line.
- out_data  out  WORD_W*WORDS  assembled line; slot k occupies bits [k*WORD_W +: WORD_W].
- busy  out  1  state != IDLE.
- abort  in  1  synchronous cancel of the current fill or held line.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, in_ready=0, word_strobe=0, busy=0, out_data=0, internal idx=0, internal cnt=0. Release is synchronous to clk.
- States: IDLE, FILL, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start_valid=1: idx<=start_idx, cnt<=0, go to FILL.
- FILL:
  - in_ready=1.
  - Each accepted word: out_data slot idx<=in_data, idx<=(idx+1) mod WORDS (wraps WORDS-1 -> 0), cnt<=cnt+1.
  - Acceptance of the WORDS-th word (cnt==WORDS-1): go to HOLD.
  - in_valid=0 cycles stall; no state change.
- HOLD:
  - out_valid=1, in_ready=0; out_data is stable.
  - On out_ready=1: go to IDLE.
  - If out_ready=1 and start_valid=1 in the same cycle: go directly to FILL with idx<=start_idx, cnt<=0. This is back-to-back fill with no IDLE bubble.
- start_valid in FILL, or in HOLD without out_ready: ignored.
- word_strobe and word_idx are combinational: word_strobe=in_valid&&in_ready, word_idx=idx. The cache uses them for early restart on the critical word.
- Latency: out_valid rises on the cycle after the final word is accepted. Minimum occupancy is 1 (start) + WORDS + 1 (handshake) cycles; back-to-back saves the IDLE cycle.
- out_data is guaranteed only while out_valid=1. Slots update in place during FILL, and stale data from earlier lines may remain in unwritten slots.
- abort=1 in any state: next state=IDLE, cnt<=0, out_valid deasserts next cycle, and no word is written that cycle (in_ready is forced 0). abort has priority over start_valid, over word acceptance, and over the out_ready/start_valid back-to-back case.
- Width rules:
  - cnt is IDX_W+1 bits wide, or compared at WORDS-1, so the fill-complete test is unambiguous.
  - idx arithmetic is modulo WORDS; no out-of-range slot is ever addressed.

Test Plan:
- Default params, reset, start_idx=0, words 0x1000_0000..0x1000_0007 sent back-to-back -> word_idx 0..7 in order; out_valid the cycle after the 8th word; out_data slot k = 0x1000_000k; out_ready=1 -> IDLE next cycle.
- start_idx=5, words A..H -> written to slots 5,6,7,0,1,2,3,4 (word_strobe on each); out_data[5*32+:32]=A and out_data[4*32+:32]=H.
- in_valid toggled 1,0,0,1,... with out_ready held 0 for 10 cycles after completion -> line completes only after 8 accepted words; out_valid stays 1 and out_data unchanged while in_ready=0 through HOLD.
- HOLD with out_ready=1 and start_valid=1 (start_idx=2) in the same cycle -> next cycle FILL, out_valid=0, first new word written to slot 2.
- abort asserted after 3 words accepted, with in_valid=1 that cycle -> that word not written; IDLE next cycle; a new start then takes a full 8 words before out_valid.
- rst_n pulsed low mid-FILL (asynchronous, between clock edges) -> out_valid, in_ready and busy go 0 immediately; out_data=0; start_valid is required before any word is accepted.
